// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell, LSB first, one bit per clock.
// Result and carry-out are registered and announced with a single-cycle done pulse.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned  CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_a, fa_b, fa_c, fa_sum, fa_carry;

    // The single full-adder cell shared by every bit position.
    assign fa_a     = opa_q[0];
    assign fa_b     = opb_q[0];
    assign fa_c     = carry_q;
    assign fa_sum   = fa_a ^ fa_b ^ fa_c;
    assign fa_carry = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // sum was cleared on accept, so OR-ing in the new bit places it at sum[cnt].
                sum_d   = sum_q | (WIDTH'(fa_sum) << cnt_q);
                carry_d = fa_carry;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    ovf_d   = carry_q ^ fa_carry;
                    cout_d  = fa_carry;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=1, 8 and 32 instances, scoreboard queues popped on done.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start1, start8, start32;
    logic [0:0]  a1, b1;
    logic [7:0]  a8, b8;
    logic [31:0] a32, b32;
    logic        cin1, cin8, cin32;
    logic        busy1, busy8, busy32;
    logic        done1, done8, done32;
    logic [0:0]  sum1;
    logic [7:0]  sum8;
    logic [31:0] sum32;
    logic        cout1, cout8, cout32;
    logic        ovf1, ovf8, ovf32;

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );
    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );
    serial_add_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];
    exp_t q32[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("busy_done_excl8", 32'(busy8 & done8), 32'd0);
        if (done8) begin
            if (q8.size() == 0) check("unexpected_done8", 32'(done8), 32'd0);
            else begin
                e = q8.pop_front();
                check("sum8", 32'(sum8), e.s);
                check("cout8", 32'(cout8), 32'(e.co));
                check("ovf8", 32'(ovf8), 32'(e.ov));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) check("unexpected_done1", 32'(done1), 32'd0);
            else begin
                e = q1.pop_front();
                check("sum1", 32'(sum1), e.s);
                check("cout1", 32'(cout1), 32'(e.co));
                check("ovf1", 32'(ovf1), 32'(e.ov));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done32) begin
            if (q32.size() == 0) check("unexpected_done32", 32'(done32), 32'd0);
            else begin
                e = q32.pop_front();
                check("sum32", sum32, e.s);
                check("cout32", 32'(cout32), 32'(e.co));
                check("ovf32", 32'(ovf32), 32'(e.ov));
            end
        end
    end

    function automatic logic dn(input int w);
        case (w)
            1:       return done1;
            8:       return done8;
            default: return done32;
        endcase
    endfunction

    function automatic logic bz(input int w);
        case (w)
            1:       return busy1;
            8:       return busy8;
            default: return busy32;
        endcase
    endfunction

    task automatic drive(input int w, input logic [31:0] x, input logic [31:0] y,
                         input logic c, input logic s);
        case (w)
            1:       begin a1 = x[0:0]; b1 = y[0:0]; cin1 = c; start1 = s; end
            8:       begin a8 = x[7:0]; b8 = y[7:0]; cin8 = c; start8 = s; end
            default: begin a32 = x; b32 = y; cin32 = c; start32 = s; end
        endcase
    endtask

    // One accepted operation; poke keeps start high with junk operands until after done.
    task automatic run_op(input int w, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input bit poke, output int lat, output int bcnt);
        logic [31:0] m;
        logic [32:0] full;
        exp_t        e;
        m      = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        full   = {1'b0, x & m} + {1'b0, y & m} + 33'(c);
        e.s    = full[31:0] & m;
        e.co   = full[w];
        e.ov   = (x[w-1] == y[w-1]) && (e.s[w-1] != x[w-1]);
        @(negedge clk);
        drive(w, x, y, c, 1'b1);
        case (w)
            1:       q1.push_back(e);
            8:       q8.push_back(e);
            default: q32.push_back(e);
        endcase
        @(posedge clk);
        #1 drive(w, $urandom, $urandom, 1'($urandom), poke);
        lat  = 0;
        bcnt = 0;
        @(negedge clk);
        while (!dn(w) && lat < w + 10) begin
            if (bz(w)) bcnt++;
            lat++;
            if (poke) drive(w, $urandom, $urandom, 1'($urandom), 1'b1);
            @(negedge clk);
        end
        check($sformatf("latency_w%0d", w), 32'(lat), 32'(w));
        if (poke) begin
            @(posedge clk);
            #1 drive(w, $urandom, $urandom, 1'($urandom), 1'b0);
        end
    endtask

    initial begin
        int lat, bc;
        rst = 1'b1;
        drive(1, 0, 0, 1'b0, 1'b0);
        drive(8, 0, 0, 1'b0, 1'b0);
        drive(32, 0, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_sum8", 32'(sum8), 32'd0);
        check("rst_cout8", 32'(cout8), 32'd0);
        check("rst_ovf8", 32'(ovf8), 32'd0);
        check("rst_sum32", sum32, 32'd0);
        rst = 1'b0;

        run_op(8, 32'h5A, 32'h3C, 1'b0, 1'b0, lat, bc);
        check("busy_cycles8", 32'(bc), 32'd8);
        // Each of these is accepted at the earliest legal edge after the previous done.
        run_op(8, 32'hFF, 32'h01, 1'b0, 1'b0, lat, bc);
        run_op(8, 32'h7F, 32'h00, 1'b1, 1'b0, lat, bc);
        run_op(8, 32'hFF, 32'hFF, 1'b1, 1'b0, lat, bc);

        run_op(8, 32'h01, 32'h02, 1'b0, 1'b1, lat, bc);
        @(negedge clk);
        check("no_reaccept_busy8", 32'(busy8), 32'd0);
        check("held_sum8", 32'(sum8), 32'h03);

        run_op(8, 32'h80, 32'h80, 1'b0, 1'b0, lat, bc);
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_abort", 32'(busy8), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy8", 32'(busy8), 32'd0);
        check("abort_done8", 32'(done8), 32'd0);
        check("abort_sum8", 32'(sum8), 32'd0);
        check("abort_cout8", 32'(cout8), 32'd0);
        check("abort_ovf8", 32'(ovf8), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_idle8", 32'(busy8), 32'd0);
        run_op(8, 32'h12, 32'h34, 1'b1, 1'b0, lat, bc);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            run_op(1, {31'd0, v[2]}, {31'd0, v[1]}, v[0], 1'b0, lat, bc);
        end

        for (int i = 0; i < 1000; i++) run_op(8, $urandom, $urandom, 1'($urandom), 1'b0, lat, bc);
        for (int i = 0; i < 1000; i++) run_op(32, $urandom, $urandom, 1'($urandom), 1'b0, lat, bc);

        repeat (4) @(negedge clk);
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q32_drained", 32'(q32.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
